// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared parity encoding, TX/RX state enums and config helpers.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE3 = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < 4'd5)
            return 4'd5;
        else if (len > max_len)
            return max_len;
        return len;
    endfunction

    function automatic logic parity_en(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Baud tick divider; reloads div-1, ticks at 0, restartable.
// Revision    : 1.0
// ============================================================================
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] w_reload;

    // A divisor of 0 behaves as 1: reload of 0 ticks every cycle.
    assign w_reload = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
    assign tick_o   = (cnt_q == '0) && !restart_i;

    always_comb begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
        if (restart_i || (cnt_q == '0))
            cnt_d = w_reload;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule
`default_nettype wire

// File: rtl/uart_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cfg
// Description : Runtime-configurable UART (5..DATA_BITS data, parity, 1/2 stop).
// Revision    : 1.0
// ============================================================================
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [3:0]           data_len,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    input  logic                 rx,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 tx_busy,
    output logic                 rx_busy
);
    localparam int unsigned       c_os_w    = $clog2(OVERSAMPLE);
    localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0] c_mid_lo  = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0] c_mid     = c_os_w'(OVERSAMPLE / 2);
    localparam logic [c_os_w-1:0] c_mid_hi  = c_os_w'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]        c_max_len = 4'(DATA_BITS);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_params
            $error("uart_cfg: illegal DATA_BITS or OVERSAMPLE");
        end
    endgenerate

    function automatic logic [DATA_BITS-1:0] len_mask(input logic [3:0] len);
        logic [DATA_BITS-1:0] m;
        for (int i = 0; i < DATA_BITS; i++)
            m[i] = (i < int'(len));
        return m;
    endfunction

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [c_os_w-1:0]    tx_os_q, tx_os_d;
    logic [3:0]           tx_bit_q, tx_bit_d, tx_len_q, tx_len_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
    logic                 tx_two_q, tx_two_d, tx_stop2_q, tx_stop2_d;
    logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d;
    logic                 tx_q, tx_d;
    logic [3:0]           w_tx_len;
    logic [DATA_BITS-1:0] w_tx_masked;
    logic                 w_tx_hs, w_tx_tick, w_tx_bit_end;

    assign w_tx_len     = clamp_len(data_len, c_max_len);
    assign w_tx_masked  = tx_data & len_mask(w_tx_len);
    assign tx_ready     = (tx_state_q == TX_IDLE) && !rst;
    assign w_tx_hs      = tx_valid && tx_ready;
    assign w_tx_bit_end = w_tx_tick && (tx_os_q == c_os_last);
    assign tx           = tx_q;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (w_tx_hs),
        .div_i     (w_tx_hs ? baud_div : tx_div_q),
        .tick_o    (w_tx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_len_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_two_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_div_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_len_q   <= tx_len_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_two_q   <= tx_two_d;
            tx_stop2_q <= tx_stop2_d;
            tx_div_q   <= tx_div_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_len_d   = tx_len_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_two_d   = tx_two_q;
        tx_stop2_d = tx_stop2_q;
        tx_div_d   = tx_div_q;
        if (tx_state_q != TX_IDLE && w_tx_tick)
            tx_os_d = w_tx_bit_end ? '0 : tx_os_q + c_os_w'(1);
        case (tx_state_q)
            TX_IDLE: if (w_tx_hs) begin
                tx_state_d = TX_START;
                tx_os_d    = '0;
                tx_len_d   = w_tx_len;
                tx_shift_d = w_tx_masked;
                tx_par_d   = (^w_tx_masked) ^ (parity_mode == PAR_ODD);
                tx_pen_d   = parity_en(parity_mode);
                tx_two_d   = two_stop;
                tx_div_d   = baud_div;
            end
            TX_START: if (w_tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (w_tx_bit_end) begin
                tx_bit_d   = tx_bit_q + 4'd1;
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == tx_len_q - 4'd1) begin
                    tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
                    tx_stop2_d = 1'b0;
                end
            end
            TX_PARITY: if (w_tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_stop2_d = 1'b0;
            end
            TX_STOP: if (w_tx_bit_end) begin
                if (tx_two_q && !tx_stop2_q)
                    tx_stop2_d = 1'b1;
                else
                    tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx leaves a flop cleanly.
    always_comb begin
        tx_d    = 1'b1;
        tx_busy = (tx_state_q != TX_IDLE);
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s2_q;
    logic [c_os_w-1:0]    rx_os_q, rx_os_d;
    logic [3:0]           rx_bit_q, rx_bit_d, rx_len_q, rx_len_d;
    logic                 rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
    logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [1:0]           rx_samp_q, rx_samp_d;
    logic                 rx_parbit_q, rx_parbit_d;
    logic                 w_rx_start, w_rx_tick, w_rx_active, w_rx_bit_end, w_rx_dec, w_rx_maj;
    logic                 w_rx_done, w_rx_ferr, w_rx_perr, w_rx_brk, w_pop;
    logic                 hold_valid_q, hold_perr_q, hold_ferr_q, hold_brk_q, ovr_q;
    logic [DATA_BITS-1:0] hold_data_q;

    assign w_rx_start   = (rx_state_q == RX_IDLE) && !rx_s2_q;
    assign w_rx_active  = (rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT_HIGH);
    assign w_rx_bit_end = w_rx_active && w_rx_tick && (rx_os_q == c_os_last);
    assign w_rx_dec     = w_rx_active && w_rx_tick && (rx_os_q == c_mid_hi);
    assign w_rx_maj     = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_s2_q) |
                          (rx_samp_q[1] & rx_s2_q);
    assign w_pop        = hold_valid_q && rx_ready;

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (w_rx_start),
        .div_i     (w_rx_start ? baud_div : rx_div_q),
        .tick_o    (w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_os_q     <= '0;
            rx_bit_q    <= '0;
            rx_len_q    <= '0;
            rx_pen_q    <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_div_q    <= '0;
            rx_shift_q  <= '0;
            rx_samp_q   <= '0;
            rx_parbit_q <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_state_q  <= rx_state_d;
            rx_os_q     <= rx_os_d;
            rx_bit_q    <= rx_bit_d;
            rx_len_q    <= rx_len_d;
            rx_pen_q    <= rx_pen_d;
            rx_odd_q    <= rx_odd_d;
            rx_div_q    <= rx_div_d;
            rx_shift_q  <= rx_shift_d;
            rx_samp_q   <= rx_samp_d;
            rx_parbit_q <= rx_parbit_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_os_d     = rx_os_q;
        rx_bit_d    = rx_bit_q;
        rx_len_d    = rx_len_q;
        rx_pen_d    = rx_pen_q;
        rx_odd_d    = rx_odd_q;
        rx_div_d    = rx_div_q;
        rx_shift_d  = rx_shift_q;
        rx_samp_d   = rx_samp_q;
        rx_parbit_d = rx_parbit_q;
        if (w_rx_active && w_rx_tick) begin
            rx_os_d = w_rx_bit_end ? '0 : rx_os_q + c_os_w'(1);
            if (rx_os_q == c_mid_lo) rx_samp_d[0] = rx_s2_q;
            if (rx_os_q == c_mid)    rx_samp_d[1] = rx_s2_q;
        end
        case (rx_state_q)
            RX_IDLE: if (w_rx_start) begin
                rx_state_d = RX_START;
                rx_os_d    = '0;
                rx_len_d   = clamp_len(data_len, c_max_len);
                rx_pen_d   = parity_en(parity_mode);
                rx_odd_d   = (parity_mode == PAR_ODD);
                rx_div_d   = baud_div;
                rx_shift_d = '0;
            end
            RX_START: begin
                if (w_rx_dec && w_rx_maj)
                    rx_state_d = RX_IDLE;
                else if (w_rx_bit_end) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                for (int i = 0; i < DATA_BITS; i++)
                    if (w_rx_dec && rx_bit_q == 4'(i))
                        rx_shift_d[i] = w_rx_maj;
                if (w_rx_bit_end) begin
                    rx_bit_d = rx_bit_q + 4'd1;
                    if (rx_bit_q == rx_len_q - 4'd1)
                        rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rx_dec)
                    rx_parbit_d = w_rx_maj;
                if (w_rx_bit_end)
                    rx_state_d = RX_STOP;
            end
            // Only the first stop bit is examined; the frame ends at its mid-bit.
            RX_STOP: if (w_rx_dec)
                rx_state_d = w_rx_maj ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s2_q)
                rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (rx_state_q != RX_IDLE);
        w_rx_done = (rx_state_q == RX_STOP) && w_rx_dec;
        w_rx_ferr = !w_rx_maj;
        w_rx_perr = rx_pen_q && (rx_parbit_q != ((^rx_shift_q) ^ rx_odd_q));
        w_rx_brk  = w_rx_ferr && (rx_shift_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_perr_q  <= 1'b0;
            hold_ferr_q  <= 1'b0;
            hold_brk_q   <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            ovr_q <= w_rx_done && hold_valid_q && !w_pop;
            if (w_rx_done && (!hold_valid_q || w_pop)) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= rx_shift_q;
                hold_perr_q  <= w_rx_perr;
                hold_ferr_q  <= w_rx_ferr;
                hold_brk_q   <= w_rx_brk;
            end else if (w_pop) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

    assign rx_valid      = hold_valid_q;
    assign rx_data       = hold_data_q;
    assign rx_parity_err = hold_perr_q;
    assign rx_frame_err  = hold_ferr_q;
    assign rx_break      = hold_brk_q;
    assign rx_overrun    = ovr_q;
endmodule
`default_nettype wire

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the maximum data bits per frame; legal values are 5 to 9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning baud ticks per bit; it shall be even and at least 8.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, meaning the width of the runtime baud divisor.
REQ-004 SHALL have these ports; reset rst, synchronous, active-high; clock clk:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 baud_div  in  DIV_WIDTH  clk cycles per baud tick; 0 treated as 1
 data_len  in  4  data bits per frame, 5..DATA_BITS; out-of-range values clamped
 parity_mode  in  2  0 none, 1 even, 2 odd, 3 none
 two_stop  in  1  TX sends 2 stop bits
 tx_valid  in  1  TX byte offered
 tx_ready  out  1  TX accepts byte
 tx_data  in  DATA_BITS  TX byte, LSB first on line
 tx  out  1  serial out, idle high
 rx  in  1  serial in, asynchronous
 rx_valid  out  1  held RX byte available
 rx_ready  in  1  consumer takes held byte
 rx_data  out  DATA_BITS  received byte, zero-extended above data_len
 rx_parity_err  out  1  parity mismatch, qualified by rx_valid
 rx_frame_err  out  1  stop bit low, qualified by rx_valid
 rx_break  out  1  frame error with all data bits 0, qualified by rx_valid
 rx_overrun  out  1  one-cycle pulse: completed frame dropped because the holding register was full
 tx_busy, rx_busy  out  1 each  FSM not idle

Function
REQ-010 SHALL generate independent RX and TX baud ticks. Each tick counter reloads baud_div-1 and ticks at 0. The counter restarts on frame start. Bit period = OVERSAMPLE*baud_div clk.
REQ-011 SHALL sample configuration inputs at TX handshake for TX and at start-bit detection for RX; mid-frame changes have no effect.
REQ-012 SHALL implement TX FSM states IDLE, START, DATA, PARITY, STOP. tx_ready=1 only in IDLE. Handshake = tx_valid&&tx_ready. tx goes low the cycle after the handshake.
REQ-013 SHALL hold each TX bit for exactly one bit period. PARITY is skipped for mode 0/3. Even parity = XOR of data bits; odd parity = its inverse. STOP lasts 1 or 2 periods. IDLE is re-entered at STOP end, and tx_ready rises that cycle.
REQ-014 SHALL pass rx through a 2-flop synchroniser reset to 1. All RX decisions use the synchronised value.
REQ-015 SHALL implement RX FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. IDLE goes to START on synchronised low.
REQ-016 SHALL take each RX bit value as a majority of 3 samples at ticks OVERSAMPLE/2-1, /2, /2+1 within the bit.
REQ-017 SHALL return START to IDLE silently if the start-bit majority is 1, with no flags raised.
REQ-018 SHALL check only the first stop bit. At its mid-bit decision the frame completes. RX returns to IDLE if the stop bit is high, otherwise goes to WAIT_HIGH until the line reads 1.
REQ-019 SHALL write a completed frame into a one-entry holding register. rx_valid is held until rx_valid&&rx_ready. A completion in the same cycle as a pop is stored without overrun.
REQ-020 SHALL drop a completed frame if the holding register is full and not popped that cycle, and pulse rx_overrun for 1 cycle; held contents stay unchanged.
REQ-021 SHALL never emit tx glitches; tx is registered.

Reset
REQ-030 SHALL on rst force tx=1, tx_ready=0 during reset and 1 the cycle after, rx_valid=0, rx_data=0, all error flags 0, both FSMs IDLE, and the synchroniser to 1.
REQ-031 SHALL abort any frame in progress on rst. Mid-frame reset returns tx high the next cycle, with no partial byte delivered.

Structure
REQ-040 SHALL place the parity_mode encoding and the TX/RX state enums in shared package uart_pkg.
REQ-041 SHALL instantiate sub-module uart_baud_tick (divisor counter with restart input) twice, once each for RX and TX.

Verification
REQ-050 TX 8N1, baud_div=4, tx_data=0xA5: tx low 64 clk, then 1,0,1,0,0,1,0,1 at 64 clk each, high 64 clk; tx_ready returns 640 clk after handshake.
REQ-051 Loopback tx->rx, 8E1, baud_div=4, 0x3C: rx_valid=1, rx_data=0x3C, parity_err=0, frame_err=0.
REQ-052 Odd parity, injected frame 0x01 with parity bit 1: rx_data=0x01, rx_parity_err=1.
REQ-053 rx low for 20 clk at baud_div=4: no rx_valid, rx_busy returns 0.
REQ-054 rx held low for 12 bit periods: one rx_valid with rx_data=0x00, frame_err=1, break=1; no further rx_valid until rx goes high and a new start bit arrives.
REQ-055 Two frames 0x11, 0x22 with rx_ready=0: rx_data stays 0x11, rx_overrun pulses once; rst mid-TX gives tx=1 the next cycle.
